// File: rtl/mux_nto1_arb.sv
// Registered N-to-1 selector with per-channel valid/ready, fixed-priority or round-robin grant.
// One cycle latency; the output register holds under backpressure, and while stalled no input is granted.
module mux_nto1_arb #(
  parameter int WIDTH  = 4,
  parameter int NUM_IN = 4,
  parameter int MODE   = 0,
  parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_sel
);

  logic [WIDTH-1:0]  data_q, data_d;
  logic              vld_q, vld_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              load_en;
  logic              grant_vld;
  logic [SEL_W-1:0]  grant_idx;
  logic [SEL_W-1:0]  cand;
  logic [NUM_IN-1:0] grant_oh;
  logic [WIDTH-1:0]  grant_dat;

  assign load_en = !vld_q || out_ready;

  // Search order starts at rr_ptr in round-robin mode, at channel 0 otherwise.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (MODE == 1) begin
        cand = SEL_W'((int'(rr_ptr_q) + k) % NUM_IN);
      end else begin
        cand = SEL_W'(k);
      end
      if (!grant_vld && in_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant_oh  = '0;
    grant_dat = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_vld && (grant_idx == SEL_W'(i))) begin
        grant_oh[i] = 1'b1;
        grant_dat   = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = (load_en && !rst) ? grant_oh : '0;

  always_comb begin
    data_d   = data_q;
    vld_d    = vld_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    if (load_en) begin
      if (grant_vld) begin
        data_d = grant_dat;
        sel_d  = grant_idx;
        vld_d  = 1'b1;
        if (MODE == 1) begin
          rr_ptr_d = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
        end
      end else begin
        vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      vld_q    <= 1'b0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      data_q   <= data_d;
      vld_q    <= vld_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = vld_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_mux_nto1_arb.sv
// Bench for mux_nto1_arb: a fixed-priority and a round-robin instance share stimulus
// and are checked against a per-mode reference model.
module tb_mux_nto1_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0]  rdy [2];
  logic [3:0]  od  [2];
  logic        ov  [2];
  logic [1:0]  os  [2];

  int checks = 0;
  int errors = 0;

  // Reference model state, index = MODE
  logic        m_vld [2];
  logic [3:0]  m_dat [2];
  int          m_sel [2];
  int          m_ptr [2];

  always #5 clk = ~clk;

  mux_nto1_arb #(.WIDTH(4), .NUM_IN(4), .MODE(0)) u_fixed (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[0]),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_sel(os[0])
  );

  mux_nto1_arb #(.WIDTH(4), .NUM_IN(4), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[1]),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_sel(os[1])
  );

  // Winner: lowest valid channel at or above the pointer, else lowest valid overall.
  function automatic int pick(int mode);
    int p;
    p = (mode == 1) ? m_ptr[mode] : 0;
    for (int i = p; i < 4; i++) if (in_valid[i]) return i;
    for (int i = 0; i < p; i++) if (in_valid[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] exp_rdy(int mode);
    int g;
    if (rst) return 4'b0000;
    if (m_vld[mode] && !out_ready) return 4'b0000;
    g = pick(mode);
    if (g < 0) return 4'b0000;
    return 4'(1 << g);
  endfunction

  task automatic tick();
    int g;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_vld[m] = 1'b0; m_dat[m] = 4'd0; m_sel[m] = 0; m_ptr[m] = 0;
      end else if (!m_vld[m] || out_ready) begin
        g = pick(m);
        if (g >= 0) begin
          m_vld[m] = 1'b1;
          m_dat[m] = in_data[g*4 +: 4];
          m_sel[m] = g;
          if (m == 1) m_ptr[m] = (g + 1) % 4;
        end else begin
          m_vld[m] = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_data = 16'h4321; in_valid = 4'b1111; out_ready = 1'b1; rst = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (rdy[m] !== 4'b0000) begin errors++; $display("FAIL reset_in_ready m%0d got %b want 0000", m, rdy[m]); end
    end
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ({ov[m], od[m], os[m]} !== 7'd0) begin
        errors++; $display("FAIL reset_out m%0d got v%b d%0d s%0d want 0", m, ov[m], od[m], os[m]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_fixed_priority();
    in_data = 16'h4321; in_valid = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (rdy[0] !== 4'b0001) begin errors++; $display("FAIL fixed_all_rdy cyc%0d got %b want 0001", c, rdy[0]); end
      tick();
      checks++;
      if (od[0] !== 4'd1 || os[0] !== 2'd0 || ov[0] !== 1'b1) begin
        errors++; $display("FAIL fixed_all_out cyc%0d got d%0d s%0d want d1 s0", c, od[0], os[0]);
      end
    end
    in_valid = 4'b1100;
    #1;
    checks++;
    if (rdy[0] !== 4'b0100) begin errors++; $display("FAIL fixed_1100_rdy got %b want 0100", rdy[0]); end
    tick();
    checks++;
    if (od[0] !== 4'd3 || os[0] !== 2'd2 || ov[0] !== 1'b1) begin
      errors++; $display("FAIL fixed_1100_out got d%0d s%0d v%b want d3 s2 v1", od[0], os[0], ov[0]);
    end
  endtask

  task automatic test_round_robin();
    int seq [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    in_data = 16'h4321; in_valid = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (os[1] !== 2'(seq[c]) || od[1] !== 4'(seq[c] + 1) || ov[1] !== 1'b1) begin
        errors++; $display("FAIL rr_seq cyc%0d got s%0d d%0d want s%0d d%0d", c, os[1], od[1], seq[c], seq[c] + 1);
      end
    end
  endtask

  task automatic test_rr_wrap();
    logic [3:0] want [3] = '{4'b1000, 4'b0010, 4'b1000};
    do_reset();
    in_data = 16'h4321; out_ready = 1'b1;
    in_valid = 4'b0010;
    tick();
    in_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (rdy[1] !== want[c]) begin errors++; $display("FAIL rr_wrap_rdy cyc%0d got %b want %b", c, rdy[1], want[c]); end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    in_data = 16'h4321; in_valid = 4'b1111; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (rdy[m] !== 4'b0000) begin errors++; $display("FAIL stall_rdy m%0d cyc%0d got %b want 0000", m, c, rdy[m]); end
      end
      tick();
      checks++;
      if (ov[1] !== 1'b1 || od[1] !== 4'd1 || os[1] !== 2'd0) begin
        errors++; $display("FAIL stall_hold cyc%0d got v%b d%0d s%0d want v1 d1 s0", c, ov[1], od[1], os[1]);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (rdy[1] !== 4'b0010) begin errors++; $display("FAIL stall_resume_rdy got %b want 0010", rdy[1]); end
    tick();
    checks++;
    if (os[1] !== 2'd1 || od[1] !== 4'd2) begin errors++; $display("FAIL stall_resume_out got s%0d d%0d want s1 d2", os[1], od[1]); end
  endtask

  task automatic test_reset_under_stall();
    in_data = 16'h4321; in_valid = 4'b0100; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 4'b1111; rst = 1'b1;
    #1;
    checks++;
    if (rdy[1] !== 4'b0000) begin errors++; $display("FAIL rst_stall_rdy got %b want 0000", rdy[1]); end
    tick();
    rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ({ov[m], od[m], os[m]} !== 7'd0) begin
        errors++; $display("FAIL rst_stall_out m%0d got v%b d%0d s%0d want 0", m, ov[m], od[m], os[m]);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (rdy[1] !== 4'b0001) begin errors++; $display("FAIL rst_first_grant got %b want 0001", rdy[1]); end
    tick();
  endtask

  task automatic test_idle();
    in_data = 16'h4521; in_valid = 4'b0100; out_ready = 1'b1;
    tick();
    in_valid = 4'b0000;
    #1;
    checks++;
    if (rdy[0] !== 4'b0000) begin errors++; $display("FAIL idle_rdy got %b want 0000", rdy[0]); end
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (ov[m] !== 1'b0 || od[m] !== 4'd5 || os[m] !== 2'd2) begin
        errors++; $display("FAIL idle_hold m%0d got v%b d%0d s%0d want v0 d5 s2", m, ov[m], od[m], os[m]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_data   = 16'($urandom);
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 40) == 0);
      #1;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (rdy[m] !== exp_rdy(m)) begin
          errors++; $display("FAIL rand_rdy m%0d cyc%0d got %b want %b", m, c, rdy[m], exp_rdy(m));
        end
      end
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (ov[m] !== m_vld[m] || od[m] !== m_dat[m] || os[m] !== 2'(m_sel[m])) begin
          errors++; $display("FAIL rand_out m%0d cyc%0d got v%b d%0d s%0d want v%b d%0d s%0d",
                             m, c, ov[m], od[m], os[m], m_vld[m], m_dat[m], m_sel[m]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = '0; out_ready = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_vld[m] = 1'b0; m_dat[m] = '0; m_sel[m] = 0; m_ptr[m] = 0;
    end
    @(negedge clk);
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_rr_wrap();
    test_stall();
    test_reset_under_stall();
    test_idle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
